// File: rtl/xor_cipher_pkg.sv
// Shared types and width helpers for the XOR stream cipher.
// Default sizes match the original fixed 32-bit-key / 512-bit-message top.
package xor_cipher_pkg;

  localparam int DEF_KEY_W = 32;
  localparam int DEF_MSG_W = 512;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_MSG = 2'd1,
    ST_OUTPUT   = 2'd2
  } state_e;

  // Counter width able to hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  // Index width addressing bits 0..n-1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xor_serial_tx.sv
// Output-stage serialiser: walks the stored ciphertext one bit per valid/ready
// handshake and flags the first and last bit of the message.
module xor_serial_tx
  import xor_cipher_pkg::*;
#(
  parameter int  MSG_W = DEF_MSG_W,
  localparam int MCW   = cnt_w(MSG_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [MSG_W-1:0] msg_i,
  input  logic [MCW-1:0]   len_i,
  input  logic             ready_i,
  output logic             bit_o,
  output logic             valid_o,
  output logic             start_o,
  output logic             end_o,
  output logic             done_o
);

  localparam int MIW = idx_w(MSG_W);

  logic [MCW-1:0] ocnt_q, ocnt_d;
  logic [MCW-1:0] len_q, len_d;
  logic           valid_q, valid_d;
  logic           bit_q, bit_d;
  logic           last_q, last_d;
  logic [MCW-1:0] ocnt_nxt;

  assign ocnt_nxt = ocnt_q + MCW'(1);

  // Handshake: a bit is consumed in a cycle where valid_o and ready_i are both 1;
  // without ready_i the bit and both flags hold unchanged.
  always_comb begin
    ocnt_d  = ocnt_q;
    len_d   = len_q;
    valid_d = valid_q;
    bit_d   = bit_q;
    last_d  = last_q;
    if (start_i) begin
      ocnt_d  = '0;
      len_d   = len_i;
      valid_d = 1'b1;
      bit_d   = msg_i[0];
      last_d  = (len_i == MCW'(1));
    end else if (valid_q && ready_i) begin
      if (last_q) begin
        ocnt_d  = '0;
        len_d   = '0;
        valid_d = 1'b0;
        bit_d   = 1'b0;
        last_d  = 1'b0;
      end else begin
        ocnt_d = ocnt_nxt;
        bit_d  = msg_i[ocnt_nxt[MIW-1:0]];
        last_d = (ocnt_nxt == len_q - MCW'(1));
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ocnt_q  <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      bit_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      ocnt_q  <= ocnt_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
    end
  end

  assign bit_o   = bit_q;
  assign valid_o = valid_q;
  assign start_o = valid_q && (ocnt_q == '0);
  assign end_o   = last_q;
  assign done_o  = valid_q && ready_i && last_q;

endmodule

// File: rtl/xor_stream_cipher.sv
// Serial key/message loader with on-the-fly XOR and a handshaked serial output.
// Define XOR_KEY_ROLL_EN to rotate a working key copy at every key-period wrap.
module xor_stream_cipher
  import xor_cipher_pkg::*;
#(
  parameter int  KEY_W = DEF_KEY_W,
  parameter int  MSG_W = DEF_MSG_W,
  localparam int KCW   = cnt_w(KEY_W),
  localparam int MCW   = cnt_w(MSG_W)
) (
  input  logic           iClk,
  input  logic           iRst,
  input  logic           iEn,
  input  logic           iSerial_in,
  input  logic           iLoad_key,
  input  logic           iLoad_msg,
  input  logic           iReady,
  output logic           oSerial_out,
  output logic           oSerial_valid,
  output logic           oSerial_start,
  output logic           oSerial_end,
  output logic           oKey_valid,
  output logic           oBusy,
  output logic           oErr,
  output logic [MCW-1:0] oMsg_len
);

  localparam int KIW = idx_w(KEY_W);
  localparam int MIW = idx_w(MSG_W);
  localparam logic [KCW-1:0] KEY_N     = KCW'(KEY_W);
  localparam logic [MCW-1:0] MSG_LAST  = MCW'(MSG_W - 1);
  localparam logic [KIW-1:0] KIDX_LAST = KIW'(KEY_W - 1);

  state_e           state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KCW-1:0]   kcnt_q, kcnt_d;
  logic             key_valid_q, key_valid_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic [MCW-1:0]   mcnt_q, mcnt_d;
  logic [KIW-1:0]   kidx_q, kidx_d;
  logic [MCW-1:0]   len_q, len_d;
  logic             err_q, err_d;

  logic msg_take, load_last, load_end, key_bit, tx_start, tx_done;

  assign msg_take  = iEn && iLoad_msg && !iLoad_key &&
                     (((state_q == ST_IDLE) && key_valid_q) || (state_q == ST_LOAD_MSG));
  assign load_last = msg_take && (state_q == ST_LOAD_MSG) && (mcnt_q == MSG_LAST);
  assign load_end  = (state_q == ST_LOAD_MSG) && (load_last || !iLoad_msg);

`ifdef XOR_KEY_ROLL_EN
  logic [KEY_W-1:0] wkey_q, wkey_d;
  // The first bit of a message is taken while the working copy is still loading.
  assign key_bit = (state_q == ST_IDLE) ? key_q[kidx_q] : wkey_q[kidx_q];

  always_comb begin
    wkey_d = wkey_q;
    if (msg_take && (state_q == ST_IDLE)) begin
      wkey_d = key_q;
    end else if (msg_take && (kidx_q == KIDX_LAST)) begin
      wkey_d = {wkey_q[KEY_W-2:0], wkey_q[KEY_W-1]};
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) wkey_q <= '0;
    else       wkey_q <= wkey_d;
  end
`else
  assign key_bit = key_q[kidx_q];
`endif

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (msg_take) state_d = ST_LOAD_MSG;
      ST_LOAD_MSG: if (load_end) state_d = ST_OUTPUT;
      ST_OUTPUT:   if (tx_done)  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    oBusy    = (state_q != ST_IDLE);
    tx_start = load_end;
  end

  always_comb begin
    key_d       = key_q;
    kcnt_d      = kcnt_q;
    key_valid_d = key_valid_q;
    msg_d       = msg_q;
    mcnt_d      = mcnt_q;
    kidx_d      = kidx_q;
    len_d       = len_q;
    err_d       = 1'b0;

    // Key capture lives in IDLE only; a dropped window rewinds the bit counter.
    if (state_q != ST_IDLE || !iLoad_key) begin
      kcnt_d = '0;
    end else if (!iLoad_msg) begin
      if (kcnt_q == '0) key_valid_d = 1'b0;
      if (iEn && (kcnt_q != KEY_N)) begin
        key_d[kcnt_q[KIW-1:0]] = iSerial_in;
        kcnt_d                 = kcnt_q + KCW'(1);
      end
    end
    if (kcnt_q == KEY_N) key_valid_d = 1'b1;

    if (iEn) begin
      if (iLoad_key && (iLoad_msg || (state_q != ST_IDLE))) err_d = 1'b1;
      if ((state_q == ST_IDLE) && iLoad_msg && !key_valid_q) err_d = 1'b1;
    end

    if (msg_take) begin
      msg_d[mcnt_q[MIW-1:0]] = iSerial_in ^ key_bit;
      mcnt_d                 = mcnt_q + MCW'(1);
      kidx_d                 = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIW'(1);
    end
    if (load_end) len_d = mcnt_d;

    if (tx_done) begin
      msg_d  = '0;
      mcnt_d = '0;
      kidx_d = '0;
      len_d  = '0;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      key_q       <= '0;
      kcnt_q      <= '0;
      key_valid_q <= 1'b0;
      msg_q       <= '0;
      mcnt_q      <= '0;
      kidx_q      <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      key_q       <= key_d;
      kcnt_q      <= kcnt_d;
      key_valid_q <= key_valid_d;
      msg_q       <= msg_d;
      mcnt_q      <= mcnt_d;
      kidx_q      <= kidx_d;
      len_q       <= len_d;
      err_q       <= err_d;
    end
  end

  xor_serial_tx #(
    .MSG_W (MSG_W)
  ) u_tx (
    .clk_i   (iClk),
    .rst_ni  (iRst),
    .start_i (tx_start),
    .msg_i   (msg_q),
    .len_i   (len_d),
    .ready_i (iReady),
    .bit_o   (oSerial_out),
    .valid_o (oSerial_valid),
    .start_o (oSerial_start),
    .end_o   (oSerial_end),
    .done_o  (tx_done)
  );

  assign oKey_valid = key_valid_q;
  assign oErr       = err_q;
  assign oMsg_len   = len_q;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Self-checking bench for xor_stream_cipher at KEY_W=8, MSG_W=16.
// Expected ciphertexts follow XOR_KEY_ROLL_EN when it is defined.
module tb_xor_stream_cipher;

  localparam int KEY_W = 8;
  localparam int MSG_W = 16;
  localparam int MCW   = $clog2(MSG_W) + 1;
`ifdef XOR_KEY_ROLL_EN
  localparam bit ROLL = 1'b1;
`else
  localparam bit ROLL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic ser_in = 1'b0;
  logic load_key = 1'b0;
  logic load_msg = 1'b0;
  logic ready = 1'b1;
  logic ser_out, ser_valid, ser_start, ser_end, key_valid, busy, err;
  logic [MCW-1:0] msg_len;

  always #5 clk = ~clk;

  xor_stream_cipher #(
    .KEY_W (KEY_W),
    .MSG_W (MSG_W)
  ) dut (
    .iClk          (clk),
    .iRst          (rst_n),
    .iEn           (en),
    .iSerial_in    (ser_in),
    .iLoad_key     (load_key),
    .iLoad_msg     (load_msg),
    .iReady        (ready),
    .oSerial_out   (ser_out),
    .oSerial_valid (ser_valid),
    .oSerial_start (ser_start),
    .oSerial_end   (ser_end),
    .oKey_valid    (key_valid),
    .oBusy         (busy),
    .oErr          (err),
    .oMsg_len      (msg_len)
  );

  typedef struct {
    logic [KEY_W-1:0] key;
    logic [MSG_W-1:0] msg;
    int               len;
    bit               stall;
    bit               poke;
    logic [MSG_W-1:0] exp;
    logic [MSG_W-1:0] exp_roll;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];  // {start, end, bit}
  int exp_len = 0;
  int out_cnt = 0;
  logic stall_prev = 1'b0;
  logic [3:0] prev_out = '0;
  logic [3:0] pat = 4'b1001;
  logic [KEY_W-1:0] cur_key = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: pop one expected bit per handshake; flags must hold across stalls.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev)
        check("hold_during_stall", 32'({ser_valid, ser_start, ser_end, ser_out}), 32'(prev_out));
      if (ser_valid && ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_bit: got bit %0b with empty queue at %0t", ser_out, $time);
        end else begin
          check("out_start_end_bit", 32'({ser_start, ser_end, ser_out}), 32'(exp_q.pop_front()));
          check("msg_len", 32'(msg_len), 32'(exp_len));
          out_cnt++;
        end
      end
      stall_prev = ser_valid && !ready;
      prev_out   = {ser_valid, ser_start, ser_end, ser_out};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic do_load_key(input logic [KEY_W-1:0] k);
    @(posedge clk); #1;
    en = 1'b1;
    load_key = 1'b1;
    for (int i = 0; i < KEY_W; i++) begin
      ser_in = k[i];
      @(posedge clk); #1;
      if (i == 0) check("key_valid_cleared_on_reload", 32'(key_valid), 32'(0));
    end
    load_key = 1'b0;
    en = 1'b0;
    ser_in = 1'b0;
    @(posedge clk); #1;
    check("key_valid_set", 32'(key_valid), 32'(1));
    cur_key = k;
  endtask

  task automatic pulse_err(input string name, input logic lk, input logic lm, input logic kv);
    @(posedge clk); #1;
    en = 1'b1;
    load_key = lk;
    load_msg = lm;
    ser_in = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    load_key = 1'b0;
    load_msg = 1'b0;
    ser_in = 1'b0;
    check({name, "_err"}, 32'(err), 32'(1));
    check({name, "_busy"}, 32'(busy), 32'(0));
    @(posedge clk); #1;
    check({name, "_err_one_cycle"}, 32'(err), 32'(0));
    check({name, "_key_valid"}, 32'(key_valid), 32'(kv));
  endtask

  task automatic run_msg(input logic [MSG_W-1:0] m, input int len, input logic [MSG_W-1:0] exp,
                         input bit stall, input bit poke);
    for (int i = 0; i < len; i++) exp_q.push_back({(i == 0), (i == len - 1), exp[i]});
    exp_len = len;
    out_cnt = 0;
    @(posedge clk); #1;
    en = 1'b1;
    load_msg = 1'b1;
    for (int i = 0; i < len; i++) begin
      ser_in = m[i];
      @(posedge clk); #1;
    end
    load_msg = 1'b0;
    en = 1'b0;
    ser_in = 1'b0;
    if (len == MSG_W) begin
      check("latency_full", 32'(ser_valid), 32'(1));
    end else begin
      check("short_still_loading", 32'({busy, ser_valid}), 32'(2'b10));
      @(posedge clk); #1;
      check("latency_short", 32'(ser_valid), 32'(1));
    end
    for (int c = 0; c < 200 && busy; c++) begin
      ready = stall ? pat[c[1:0]] : 1'b1;
      if (poke && c == 1) begin
        load_key = 1'b1;
        en = 1'b1;
      end else begin
        load_key = 1'b0;
        en = 1'b0;
      end
      @(posedge clk); #1;
      if (poke && c == 1) check("err_key_in_output", 32'(err), 32'(1));
    end
    ready = 1'b1;
    load_key = 1'b0;
    en = 1'b0;
    check("done_not_busy", 32'(busy), 32'(0));
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    check("bit_count", 32'(out_cnt), 32'(len));
    check("idle_valid_low", 32'(ser_valid), 32'(0));
    exp_q.delete();
  endtask

  initial begin
    vec_t vecs[6];
    vecs[0] = '{8'hB2, 16'hFFFF, 16, 1'b0, 1'b0, 16'h4D4D, 16'h9A4D};
    vecs[1] = '{8'hB2, 16'h0015,  5, 1'b0, 1'b0, 16'h0007, 16'h0007};
    vecs[2] = '{8'h5A, 16'h1234, 16, 1'b0, 1'b1, 16'h486E, 16'hA66E};
    vecs[3] = '{8'h5A, 16'h00A7, 12, 1'b1, 1'b0, 16'h0AFD, 16'h04FD};
    vecs[4] = '{8'hFF, 16'h0001,  1, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vecs[5] = '{8'h01, 16'h0000, 16, 1'b0, 1'b0, 16'h0101, 16'h0201};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_valid", 32'(ser_valid), 32'(0));
    check("reset_flags_out", 32'({ser_start, ser_end, ser_out}), 32'(0));
    check("reset_key_valid", 32'(key_valid), 32'(0));
    check("reset_busy_err", 32'({busy, err}), 32'(0));
    check("reset_msg_len", 32'(msg_len), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    pulse_err("msg_without_key", 1'b0, 1'b1, 1'b0);
    do_load_key(8'hB2);
    pulse_err("key_and_msg_together", 1'b1, 1'b1, 1'b1);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].key != cur_key) do_load_key(vecs[v].key);
      run_msg(vecs[v].msg, vecs[v].len, ROLL ? vecs[v].exp_roll : vecs[v].exp,
              vecs[v].stall, vecs[v].poke);
    end

    // Abort a load part-way through with reset, then reload from scratch.
    @(posedge clk); #1;
    en = 1'b1;
    load_msg = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ser_in = 1'b1;
      @(posedge clk); #1;
    end
    check("midload_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    load_msg = 1'b0;
    en = 1'b0;
    exp_q.delete();
    #1;
    check("midload_reset_outputs",
          32'({ser_valid, ser_start, ser_end, ser_out, key_valid, busy, err, msg_len}), 32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_reset_quiet", 32'({ser_valid, busy, key_valid}), 32'(0));
    do_load_key(vecs[0].key);
    run_msg(vecs[0].msg, vecs[0].len, ROLL ? vecs[0].exp_roll : vecs[0].exp, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
